qos_wrr_scheduler: RTL and testbench

- Weighted round-robin pop scheduler for the four QoS class FIFOs.
- Selects which FIFO to pop, issues a one-hot registered pop strobe, and flags when the popped data is valid on the shared FIFO output.
- Gives class i up to weight[i] consecutive pops per turn.
- Holds off while the flow-control FSM requests pause.
- Sits between the FIFO bank and the egress path, replacing ad-hoc pop_id decoding.

---
 rtl/qos_pkg.sv | 24 ++
 rtl/rr_next_eligible.sv | 28 ++
 rtl/qos_wrr_scheduler.sv | 125 ++++++++++++
 tb/tb_qos_wrr_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared constants, FSM encodings and helpers for the
// QoS weighted round-robin pop scheduler.
package qos_pkg;

    localparam int NUM_Q = 4;
    localparam int W_W   = 5;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_POP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    // Extract the weight of one class from the packed weight vector.
    function automatic logic [W_W-1:0] weight_of(
        input logic [NUM_Q*W_W-1:0] w,
        input logic [ID_W-1:0]      idx
    );
        weight_of = w[idx*W_W +: W_W];
    endfunction

endpackage

// File: rtl/rr_next_eligible.sv
// Rotating priority encoder: finds the first eligible class
// after ptr, wrapping around so that ptr itself is tried last.
module rr_next_eligible
    import qos_pkg::*;
(
    input  logic [NUM_Q-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Scan ptr+1, ptr+2, ptr+3, ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 1; k <= NUM_Q; k++) begin
            cand = ptr + ID_W'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin pop scheduler for four QoS class FIFOs.
// Grants up to weight[i] pops per turn, one pop every 2 cycles.
module qos_wrr_scheduler
    import qos_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 init,
    input  logic [NUM_Q*W_W-1:0] request,
    input  logic [NUM_Q-1:0]     empty,
    input  logic                 pausa,
    output logic [NUM_Q-1:0]     pop,
    output logic [ID_W-1:0]      pop_id,
    output logic                 pop_valid,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [NUM_Q*W_W-1:0] weights_q, weights_d;
    logic [W_W-1:0]       credit_q, credit_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [NUM_Q-1:0]     pop_q, pop_d;
    logic [ID_W-1:0]      pop_id_q, pop_id_d;
    logic                 pop_valid_q, pop_valid_d;

    logic [NUM_Q-1:0]     eligible;
    logic                 nxt_found;
    logic [ID_W-1:0]      nxt_idx;

    // A class may be granted only if it has data and a nonzero weight.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            eligible[i] = ~empty[i]
                & (weight_of(weights_q, ID_W'(i)) != '0);
        end
    end

    rr_next_eligible u_next (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (nxt_found),
        .idx      (nxt_idx)
    );

    // Next-state, credit and grant computation.
    always_comb begin
        state_d     = state_q;
        weights_d   = weights_q;
        credit_d    = credit_q;
        ptr_d       = ptr_q;
        pop_d       = '0;
        pop_id_d    = pop_id_q;
        pop_valid_d = |pop_q;
        if (init) begin
            weights_d = request;
            credit_d  = '0;
            ptr_d     = '1;
            state_d   = pausa ? ST_PAUSE : ST_ARB;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pausa)
                        state_d = ST_PAUSE;
                    else if (|eligible)
                        state_d = ST_ARB;
                end
                ST_ARB: begin
                    if (pausa) begin
                        state_d = ST_PAUSE;
                    end else if (eligible[ptr_q]
                                 && credit_q != '0) begin
                        credit_d = credit_q - W_W'(1);
                        pop_d    = NUM_Q'(1) << ptr_q;
                        pop_id_d = ptr_q;
                        state_d  = ST_POP;
                    end else if (nxt_found) begin
                        ptr_d    = nxt_idx;
                        credit_d = weight_of(weights_q, nxt_idx)
                                   - W_W'(1);
                        pop_d    = NUM_Q'(1) << nxt_idx;
                        pop_id_d = nxt_idx;
                        state_d  = ST_POP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_POP: begin
                    state_d = ST_ARB;
                end
                ST_PAUSE: begin
                    if (!pausa)
                        state_d = ST_ARB;
                end
            endcase
        end
    end

    // Register FSM state, arbitration context and outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            weights_q   <= {NUM_Q{W_W'(1)}};
            credit_q    <= '0;
            ptr_q       <= '1;
            pop_q       <= '0;
            pop_id_q    <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            weights_q   <= weights_d;
            credit_q    <= credit_d;
            ptr_q       <= ptr_d;
            pop_q       <= pop_d;
            pop_id_q    <= pop_id_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    assign pop       = pop_q;
    assign pop_id    = pop_id_q;
    assign pop_valid = pop_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Scoreboard bench for qos_wrr_scheduler with a simple
// FIFO occupancy model driving the empty flags.
module tb_qos_wrr_scheduler;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        init = 1'b0;
    logic        pausa = 1'b0;
    logic [19:0] request = '0;
    logic [3:0]  empty;
    logic [3:0]  pop;
    logic [1:0]  pop_id;
    logic        pop_valid;
    logic        busy;

    int fill[4];
    int popped[4];
    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    bit prev_pop_nz = 1'b0;
    int mon_e;

    always #5 CLK = ~CLK;

    qos_wrr_scheduler dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .init      (init),
        .request   (request),
        .empty     (empty),
        .pausa     (pausa),
        .pop       (pop),
        .pop_id    (pop_id),
        .pop_valid (pop_valid),
        .busy      (busy)
    );

    assign empty = {fill[3] <= popped[3], fill[2] <= popped[2],
                    fill[1] <= popped[1], fill[0] <= popped[0]};

    // FIFO read side: a strobe seen at the edge consumes one entry.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (pop[i] && fill[i] > popped[i])
                popped[i] <= popped[i] + 1;
    end

    // Monitor: pops scoreboard entries whenever a pop strobe shows.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                prev_pop_nz = 1'b0;
            end else begin
                n_cmp++;
                if (pop_valid !== prev_pop_nz) begin
                    n_err++;
                    $display("FAIL pop_valid: got %b want %b t=%0t",
                             pop_valid, prev_pop_nz, $time);
                end
                if (pop !== 4'b0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_pop: got pop=%b id=%0d want none t=%0t",
                                 pop, pop_id, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (pop !== (4'b1 << mon_e)
                            || pop_id !== mon_e[1:0]) begin
                            n_err++;
                            $display("FAIL grant: got pop=%b id=%0d want class %0d t=%0t",
                                     pop, pop_id, mon_e, $time);
                        end
                    end
                    n_cmp++;
                    if ((pop & empty) !== 4'b0) begin
                        n_err++;
                        $display("FAIL pop_empty: got pop=%b empty=%b want no overlap",
                                 pop, empty);
                    end
                end
                prev_pop_nz = (pop != 4'b0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end want finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [19:0] wts(input int w0, input int w1,
                                        input int w2, input int w3);
        return {5'(w3), 5'(w2), 5'(w1), 5'(w0)};
    endfunction

    task automatic set_fill(input int f0, input int f1,
                            input int f2, input int f3);
        fill[0] = popped[0] + f0;
        fill[1] = popped[1] + f1;
        fill[2] = popped[2] + f2;
        fill[3] = popped[3] + f3;
    endtask

    task automatic do_init(input logic [19:0] w);
        request = w;
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic push(input int id);
        exp_q.push_back(id);
    endtask

    task automatic wait_pop(input string name);
        int k = 0;
        while (pop == 4'b0 && k < 20) begin
            tick();
            k++;
        end
        check({name, "_seen"}, 32'(pop != 4'b0), 1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            tick();
            k++;
        end
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin : stim
        int p3;
        tick(2);
        check("rst_pop", 32'(pop), 0);
        check("rst_pop_id", 32'(pop_id), 0);
        check("rst_valid", 32'(pop_valid), 0);
        check("rst_busy", 32'(busy), 0);
        RESET = 1'b1;
        tick(2);

        // Equal weights: strict rotation with exact latency.
        push(0); push(1); push(2); push(3); push(0);
        set_fill(2, 1, 1, 1);
        do_init(wts(1, 1, 1, 1));
        check("t1_n0_pop", 32'(pop), 0);
        tick();
        check("t1_n1_pop", 32'(pop), 4'b0001);
        tick();
        check("t1_n2_pop", 32'(pop), 0);
        check("t1_n2_valid", 32'(pop_valid), 1);
        tick();
        check("t1_n3_pop", 32'(pop), 4'b0010);
        drain("t1");

        // Weights 3,1,2,0: class 3 never popped.
        p3 = popped[3];
        push(0); push(0); push(0); push(1);
        push(2); push(2); push(0);
        set_fill(4, 1, 2, 5);
        do_init(wts(3, 1, 2, 0));
        drain("t2");
        check("t2_class3", popped[3] - p3, 0);

        // Class 0 empties mid-turn, then returns with fresh credit.
        push(0); push(0); push(1); push(1); push(1);
        set_fill(2, 3, 0, 0);
        do_init(wts(4, 1, 0, 0));
        drain("t3a");
        repeat (5) push(0);
        set_fill(5, 0, 0, 0);
        drain("t3b");

        // Pause during the second pop; turn resumes afterwards.
        push(0); push(0); push(0); push(1);
        push(2); push(2); push(0);
        set_fill(4, 1, 2, 0);
        do_init(wts(3, 1, 2, 0));
        wait_pop("t4_first");
        tick();
        wait_pop("t4_second");
        pausa = 1'b1;
        tick();
        check("t4_valid", 32'(pop_valid), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_hold", 32'({busy, pop}), 32'h10);
        end
        pausa = 1'b0;
        drain("t4");

        // Idle wake-up: empty[2] falls, pop[2] two cycles later.
        set_fill(0, 0, 0, 0);
        tick(2);
        check("t5_idle", 32'({busy, pop}), 0);
        push(2);
        set_fill(0, 0, 1, 0);
        tick();
        check("t5_n1_pop", 32'(pop), 0);
        tick();
        check("t5_n2_pop", 32'(pop), 4'b0100);
        drain("t5");

        // Reset during a pop; default weights after release.
        push(2); push(0); push(1);
        set_fill(1, 1, 0, 0);
        do_init(wts(0, 0, 1, 0));
        set_fill(1, 1, 1, 0);
        wait_pop("t6_pop");
        #2 RESET = 1'b0;
        #1;
        check("t6_rst_pop", 32'(pop), 0);
        check("t6_rst_valid", 32'(pop_valid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        set_fill(1, 1, 0, 0);
        @(negedge CLK);
        #2 RESET = 1'b1;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
